// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared types, default constants and BCD helper for the stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  localparam int unsigned c_def_ticks_per_sec   = 100_000_000;
  localparam int unsigned c_def_debounce_cycles = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m_tens;
    bcd_t m_ones;
    bcd_t s_tens;
    bcd_t s_ones;
  } time_t;

  localparam time_t c_time_zero = '{m_tens: 4'd0, m_ones: 4'd0, s_tens: 4'd0, s_ones: 4'd0};
  localparam time_t c_time_max  = '{m_tens: 4'd5, m_ones: 4'd9, s_tens: 4'd5, s_ones: 4'd9};

  // Carry chain uses >= so an out-of-range digit can only ever fall back to 0.
  function automatic time_t time_inc(input time_t t);
    time_t r;
    r = t;
    if (t.s_ones < 4'd9) begin
      r.s_ones = t.s_ones + 4'd1;
    end else begin
      r.s_ones = 4'd0;
      if (t.s_tens < 4'd5) begin
        r.s_tens = t.s_tens + 4'd1;
      end else begin
        r.s_tens = 4'd0;
        if (t.m_ones < 4'd9) begin
          r.m_ones = t.m_ones + 4'd1;
        end else begin
          r.m_ones = 4'd0;
          if (t.m_tens < 4'd5) begin
            r.m_tens = t.m_tens + 4'd1;
          end else begin
            r.m_tens = 4'd0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_counter_debounce.sv
// ============================================================================
// Module   : button_debounce
// Purpose  : 2-FF synchronizer, counting debouncer and rising-edge press pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = c_def_debounce_cycles
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               sync1_q;
  logic               sync2_q;
  logic               level_q;
  logic               level_d;
  logic               press_q;
  logic               press_d;
  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // cnt_q tracks how many consecutive samples have disagreed with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_cnt_last) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// Module   : stopwatch_counter
// Purpose  : MM:SS stopwatch with start/stop, clear and optional lap hold
//            (lap hold present when STOPWATCH_LAP_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC   = c_def_ticks_per_sec,
  parameter int unsigned DEBOUNCE_CYCLES = c_def_debounce_cycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
`endif
  output logic [3:0] seconds_ones_counter,
  output logic [3:0] seconds_tens_counter,
  output logic [3:0] minutes_ones_counter,
  output logic [3:0] minutes_tens_counter,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned c_pre_w = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICKS_PER_SEC - 1);
  localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);

  logic               w_ss_press;
  logic               w_clr_press;
  logic               w_tick;
  state_e             state_q;
  state_e             state_d;
  logic [c_pre_w-1:0] pre_q;
  logic [c_pre_w-1:0] pre_d;
  time_t              dig_q;
  time_t              dig_d;
  logic               wrap_q;
  logic               wrap_d;
  time_t              w_disp;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_start_stop),
    .press_o (w_ss_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_clear),
    .press_o (w_clr_press)
  );

  // Clear outranks start/stop wherever clear is honoured; RUN never sees clear.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_clr_press)     state_d = ST_IDLE;
        else if (w_ss_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_ss_press)      state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_clr_press)     state_d = ST_IDLE;
        else if (w_ss_press) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign w_tick = (state_q == ST_RUN) && (pre_q == c_pre_last);

  // Prescaler only moves in RUN, so PAUSE keeps the sub-second phase.
  always_comb begin
    pre_d  = pre_q;
    dig_d  = dig_q;
    wrap_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (w_tick) begin
        pre_d  = '0;
        dig_d  = time_inc(dig_q);
        wrap_d = (dig_q == c_time_max);
      end else begin
        pre_d = pre_q + c_pre_one;
      end
    end
    if (state_d == ST_IDLE) begin
      pre_d  = '0;
      dig_d  = c_time_zero;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      dig_q  <= c_time_zero;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      dig_q  <= dig_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic  w_lap_press;
  logic  hold_q;
  logic  hold_d;
  time_t lap_q;
  time_t lap_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_lap),
    .press_o (w_lap_press)
  );

  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if ((state_q == ST_RUN) && w_lap_press) begin
      hold_d = ~hold_q;
      if (!hold_q) lap_d = dig_q;
    end
    if (state_d == ST_IDLE) hold_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      lap_q  <= c_time_zero;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
    end
  end

  assign w_disp = hold_q ? lap_q : dig_q;
`else
  assign w_disp = dig_q;
`endif

  assign seconds_ones_counter = w_disp.s_ones;
  assign seconds_tens_counter = w_disp.s_tens;
  assign minutes_ones_counter = w_disp.m_ones;
  assign minutes_tens_counter = w_disp.m_tens;
  assign running              = (state_q == ST_RUN);
  assign wrap                 = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// Module   : tb_stopwatch_counter
// Purpose  : Directed self-checking bench for stopwatch_counter
//            (TICKS_PER_SEC=10, DEBOUNCE_CYCLES=4; lap checks under STOPWATCH_LAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start_stop;
  logic       btn_clear;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap;
`endif
  logic [3:0] s1;
  logic [3:0] s10;
  logic [3:0] m1;
  logic [3:0] m10;
  logic       running;
  logic       wrap;
  logic [15:0] w_time;

  int n_chk  = 0;
  int n_fail = 0;

  stopwatch_counter #(.TICKS_PER_SEC(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .btn_start_stop       (btn_start_stop),
    .btn_clear            (btn_clear),
`ifdef STOPWATCH_LAP_EN
    .btn_lap              (btn_lap),
`endif
    .seconds_ones_counter (s1),
    .seconds_tens_counter (s10),
    .minutes_ones_counter (m1),
    .minutes_tens_counter (m10),
    .running              (running),
    .wrap                 (wrap)
  );

  always #5 clk = ~clk;

  assign w_time = {m10, m1, s10, s1};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edge numbers in comments count rising edges after reset release (E0).
  initial begin
    rst            = 1'b1;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap        = 1'b0;
`endif
    step(3);
    chk("reset_digits",  w_time, 16'h0000);
    chk("reset_running", {15'd0, running}, 16'd0);
    chk("reset_wrap",    {15'd0, wrap}, 16'd0);
    rst = 1'b0;

    btn_start_stop = 1'b1;
    step(6);
    chk("start_latency_early", {15'd0, running}, 16'd0);
    step(1);                                          // E7
    chk("start_latency", {15'd0, running}, 16'd1);
    btn_start_stop = 1'b0;
    step(9);                                          // E16
    chk("first_tick_early", w_time, 16'h0000);
    step(1);                                          // E17
    chk("first_tick", w_time, 16'h0001);

    step(9);                                          // E26
    btn_start_stop = 1'b1;
    step(7);                                          // E33 paused, prescaler 6
    btn_start_stop = 1'b0;
    chk("pause_running", {15'd0, running}, 16'd0);
    chk("pause_digits", w_time, 16'h0002);
    step(100);                                        // E133
    chk("pause_hold", w_time, 16'h0002);

    btn_start_stop = 1'b1;
    step(2);
    btn_start_stop = 1'b0;
    step(10);                                         // E145
    chk("glitch_ignored", {15'd0, running}, 16'd0);

    btn_start_stop = 1'b1;
    step(7);                                          // E152 resumed
    btn_start_stop = 1'b0;
    chk("resume_running", {15'd0, running}, 16'd1);
    step(3);                                          // E155
    chk("resume_phase_early", w_time, 16'h0002);
    step(1);                                          // E156
    chk("resume_phase_tick", w_time, 16'h0003);

    btn_clear = 1'b1;
    step(7);                                          // E163
    btn_clear = 1'b0;
    chk("clear_in_run_running", {15'd0, running}, 16'd1);
    chk("clear_in_run_digits", w_time, 16'h0003);

    step(63);                                         // E226
    chk("carry_sec_tens", w_time, 16'h0010);
    step(500);                                        // E726
    chk("carry_minutes", w_time, 16'h0100);
    step(35390);                                      // E36116
    chk("at_5959", w_time, 16'h5959);
    step(9);                                          // E36125
    chk("pre_wrap_low", {15'd0, wrap}, 16'd0);
    step(1);                                          // E36126
    chk("wrap_digits", w_time, 16'h0000);
    chk("wrap_pulse", {15'd0, wrap}, 16'd1);
    chk("wrap_running", {15'd0, running}, 16'd1);
    step(1);                                          // E36127
    chk("wrap_one_cycle", {15'd0, wrap}, 16'd0);

    step(29);                                         // E36156
    chk("after_wrap_count", w_time, 16'h0003);
    btn_start_stop = 1'b1;
    step(7);                                          // E36163
    btn_start_stop = 1'b0;
    chk("pause2_running", {15'd0, running}, 16'd0);
    chk("pause2_digits", w_time, 16'h0003);

    step(8);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    step(7);                                          // E36178
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    chk("clear_prio_running", {15'd0, running}, 16'd0);
    chk("clear_prio_digits", w_time, 16'h0000);

    step(8);
    btn_start_stop = 1'b1;
    step(7);                                          // E36193
    btn_start_stop = 1'b0;
    chk("restart_running", {15'd0, running}, 16'd1);
    step(9);                                          // E36202
    chk("prescaler_zeroed_early", w_time, 16'h0000);
    step(1);                                          // E36203
    chk("prescaler_zeroed_tick", w_time, 16'h0001);

`ifdef STOPWATCH_LAP_EN
    step(17);
    btn_lap = 1'b1;
    step(7);                                          // E36227 held at 00:03
    btn_lap = 1'b0;
    chk("lap_capture", w_time, 16'h0003);
    step(100);                                        // E36327 live 00:13
    chk("lap_frozen_mid", w_time, 16'h0003);
    step(93);
    btn_lap = 1'b1;
    step(6);                                          // E36426 live 00:23
    chk("lap_frozen_end", w_time, 16'h0003);
    step(1);                                          // E36427
    btn_lap = 1'b0;
    chk("lap_release", w_time, 16'h0023);
`endif

    rst = 1'b1;
    step(1);
    chk("rst_run_digits", w_time, 16'h0000);
    chk("rst_run_running", {15'd0, running}, 16'd0);
    rst = 1'b0;
    step(12);
    chk("rst_stays_idle", {15'd0, running}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100_000_000, meaning clk cycles per counted second.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the stable-level cycles required to accept a button level.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_start_stop  input  1  raw asynchronous push button, active-high.
REQ-006 SHALL have port btn_clear  input  1  raw asynchronous push button, active-high.
REQ-007 SHALL have port btn_lap  input  1  raw push button, present only when STOPWATCH_LAP_EN is defined.
REQ-008 SHALL have ports seconds_ones_counter, seconds_tens_counter, minutes_ones_counter, minutes_tens_counter  output  4 each  BCD digits for the display multiplexer.
REQ-009 SHALL have port running  output  1  high while in state RUN.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover.

Function
REQ-011 SHALL pass each button through a 2-FF synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES consecutive identical samples; a press event is a one-cycle pulse on the debounced rising edge.
REQ-012 SHALL implement states IDLE, RUN and PAUSE: IDLE+start_stop -> RUN; RUN+start_stop -> PAUSE; PAUSE+start_stop -> RUN; PAUSE or IDLE +clear -> IDLE; clear in RUN ignored.
REQ-013 SHALL give clear priority on a simultaneous start_stop and clear press in PAUSE or IDLE (-> IDLE); in RUN, start_stop acts and clear is ignored.
REQ-014 SHALL zero all digits and the prescaler on entry to IDLE.
REQ-015 SHALL advance the prescaler 0..TICKS_PER_SEC-1 only in RUN and hold it in PAUSE, so that resuming preserves the sub-second phase.
REQ-016 SHALL generate a second tick in the RUN cycle where prescaler == TICKS_PER_SEC-1; prescaler -> 0 and the incremented digits appear on the next cycle.
REQ-017 SHALL apply the BCD carry chain seconds_ones 9->0, seconds_tens 5->0, minutes_ones 9->0, minutes_tens 5->0; 59:59 wraps to 00:00, asserts wrap for that one cycle, and stays in RUN.
REQ-018 SHALL never output a digit value above 9 (tens digits above 5).
REQ-019 SHALL act on a press event in the cycle after the pulse; press-to-state latency is 2 + DEBOUNCE_CYCLES + 1 cycles (nominal).

Reset
REQ-020 SHALL on rst: state IDLE, all digits 0, prescaler 0, running 0, wrap 0, debouncer levels 0, lap hold cleared.
REQ-021 SHALL honour rst in any state, overriding any concurrent press or tick.

Configuration
REQ-022 SHALL, with STOPWATCH_LAP_EN defined: a lap press in RUN toggles hold; while held, the outputs are frozen at the capture-cycle value and the internal count continues; release shows the live count the next cycle; lap in IDLE/PAUSE ignored; entering IDLE clears hold.
REQ-023 SHALL, without STOPWATCH_LAP_EN: btn_lap and all hold logic are absent and the outputs always show the live count.

Structure
REQ-024 SHALL place the state enum, the 4-bit BCD digit type and the default parameter constants in package stopwatch_pkg.
REQ-025 SHALL implement the synchronizer+debouncer+edge detect as sub-module button_debounce, instantiated once per button.

Verification (TICKS_PER_SEC=10, DEBOUNCE_CYCLES=4)
REQ-026 SHALL cover: rst, start press -> running=1 after 7 cycles; 10 ticks later seconds_ones_counter=1.
REQ-027 SHALL cover: a 2-cycle glitch on btn_start_stop -> no state change.
REQ-028 SHALL cover: preload 59:59 via run, one tick -> all digits 0, wrap high exactly 1 cycle, running=1.
REQ-029 SHALL cover: pause at prescaler=6, wait 100 cycles, resume -> next increment after 4 RUN cycles.
REQ-030 SHALL cover: clear in RUN -> ignored; clear+start_stop together in PAUSE -> IDLE, digits 00:00.
REQ-031 SHALL cover (LAP_EN): lap at 00:03, run 20 ticks -> outputs show 00:03; lap again -> 00:23.
